// File: rtl/rsv_grant_serializer.sv
// Serializes a 6-bit request mask into one grant per cycle, highest bit first.
// Ports: clk/reset, in_valid/in_ready/in_mask (mask intake), out_valid/out_ready,
// out_onehot/out_idx/out_last (grant), pending (bits left including current grant).
module rsv_grant_serializer (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_mask,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_onehot,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic [2:0] pending
);

    localparam int WIDTH = 6;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] hi_onehot;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] cnt;
    logic             issuing;
    logic             accept;
    logic             fire;

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        hi_onehot = '0;
        hi_idx    = '0;
        cnt       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rem_q[i]) begin
                hi_onehot    = '0;
                hi_onehot[i] = 1'b1;
                hi_idx       = IDX_W'(i);
                cnt          = cnt + 3'd1;
            end
        end
    end

    assign issuing    = (state_q == ISSUE);
    assign out_valid  = issuing;
    assign out_onehot = issuing ? hi_onehot : '0;
    assign out_idx    = issuing ? hi_idx : '0;
    assign pending    = issuing ? cnt : '0;
    assign out_last   = issuing && (cnt == 3'd1);

    // A new mask may be taken alongside the final grant of the current one.
    assign in_ready = !reset && (!issuing || (out_ready && out_last));
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (accept) begin
            rem_d   = in_mask;
            state_d = (in_mask != '0) ? ISSUE : IDLE;
        end else if (fire) begin
            rem_d = rem_q & ~hi_onehot;
            if (out_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_rsv_grant_serializer.sv
// Directed testbench for rsv_grant_serializer.
// Observes {out_valid,out_onehot,out_idx,out_last,pending,in_ready} per cycle.
module tb_rsv_grant_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_mask;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_onehot;
    logic [2:0] out_idx;
    logic       out_last;
    logic [2:0] pending;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rsv_grant_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_onehot(out_onehot),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .pending   (pending)
    );

    logic [14:0] obs;
    assign obs = {out_valid, out_onehot, out_idx, out_last, pending, in_ready};

    function automatic logic [14:0] mk(input logic v, input logic [5:0] oh,
                                       input logic [2:0] ix, input logic l,
                                       input logic [2:0] p, input logic r);
        return {v, oh, ix, l, p, r};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] e;
        reset = 1'b1; in_valid = 1'b1; in_mask = 6'h3f; out_ready = 1'b1;
        step();
        step();
        #1;
        e = mk(0, 6'b0, 3'd0, 0, 3'd0, 0);
        total++;
        if (obs !== e) $display("FAIL reset_hold got %b want %b", obs, e);
        else passed++;
        reset = 1'b0; in_valid = 1'b0;
        #1;
        e = mk(0, 6'b0, 3'd0, 0, 3'd0, 1);
        total++;
        if (obs !== e) $display("FAIL reset_release got %b want %b", obs, e);
        else passed++;
    endtask

    task automatic test_basic();
        logic [14:0] e;
        logic [14:0] exp_seq [4];
        exp_seq[0] = mk(1, 6'b100000, 3'd5, 0, 3'd3, 0);
        exp_seq[1] = mk(1, 6'b001000, 3'd3, 0, 3'd2, 0);
        exp_seq[2] = mk(1, 6'b000001, 3'd0, 1, 3'd1, 1);
        exp_seq[3] = mk(0, 6'b000000, 3'd0, 0, 3'd0, 1);
        in_valid = 1'b1; in_mask = 6'b101001; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_mask = 6'b111111;
        for (int k = 0; k < 4; k++) begin
            #1;
            e = exp_seq[k];
            total++;
            if (obs !== e) $display("FAIL basic_c%0d got %b want %b", k, obs, e);
            else passed++;
            step();
        end
    endtask

    task automatic test_stall_toggle();
        logic [14:0] e;
        int k;
        int cyc;
        in_valid = 1'b1; in_mask = 6'b111111; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 6 && cyc < 40) begin
            out_ready = (cyc % 2 == 0);
            #1;
            e = mk(1, 6'b1 << (5 - k), 3'(5 - k), k == 5, 3'(6 - k),
                   (k == 5) && out_ready);
            total++;
            if (obs !== e) $display("FAIL toggle_c%0d got %b want %b", cyc, obs, e);
            else passed++;
            if (out_ready) k++;
            step();
            cyc++;
        end
        total++;
        if (cyc !== 11) $display("FAIL toggle_cycles got %0d want 11", cyc);
        else passed++;
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL toggle_done got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [14:0] e;
        in_valid = 1'b1; in_mask = 6'b000011; out_ready = 1'b1;
        step();
        in_mask = 6'b110000;
        #1;
        e = mk(1, 6'b000010, 3'd1, 0, 3'd2, 0);
        total++;
        if (obs !== e) $display("FAIL b2b_idx1 got %b want %b", obs, e);
        else passed++;
        step();
        e = mk(1, 6'b000001, 3'd0, 1, 3'd1, 1);
        total++;
        if (obs !== e) $display("FAIL b2b_idx0 got %b want %b", obs, e);
        else passed++;
        step();
        in_valid = 1'b0;
        #1;
        e = mk(1, 6'b100000, 3'd5, 0, 3'd2, 0);
        total++;
        if (obs !== e) $display("FAIL b2b_idx5 got %b want %b", obs, e);
        else passed++;
        step();
        e = mk(1, 6'b010000, 3'd4, 1, 3'd1, 1);
        total++;
        if (obs !== e) $display("FAIL b2b_idx4 got %b want %b", obs, e);
        else passed++;
        step();
        e = mk(0, 6'b0, 3'd0, 0, 3'd0, 1);
        total++;
        if (obs !== e) $display("FAIL b2b_idle got %b want %b", obs, e);
        else passed++;
    endtask

    task automatic test_zero_mask();
        logic [14:0] e;
        in_valid = 1'b1; in_mask = 6'b000000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        e = mk(0, 6'b0, 3'd0, 0, 3'd0, 1);
        total++;
        if (obs !== e) $display("FAIL zero_idle got %b want %b", obs, e);
        else passed++;
        in_valid = 1'b1; in_mask = 6'b000100;
        step();
        in_valid = 1'b0;
        #1;
        e = mk(1, 6'b000100, 3'd2, 1, 3'd1, 1);
        total++;
        if (obs !== e) $display("FAIL zero_next got %b want %b", obs, e);
        else passed++;
        step();
        e = mk(0, 6'b0, 3'd0, 0, 3'd0, 1);
        total++;
        if (obs !== e) $display("FAIL zero_done got %b want %b", obs, e);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [14:0] e;
        in_valid = 1'b1; in_mask = 6'b111000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        e = mk(1, 6'b100000, 3'd5, 0, 3'd3, 0);
        total++;
        if (obs !== e) $display("FAIL rmid_idx5 got %b want %b", obs, e);
        else passed++;
        step();
        reset = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL rmid_rdy got %b want 0", in_ready);
        else passed++;
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            e = mk(0, 6'b0, 3'd0, 0, 3'd0, 1);
            total++;
            if (obs !== e) $display("FAIL rmid_flush%0d got %b want %b", c, obs, e);
            else passed++;
            step();
        end
        in_valid = 1'b1; in_mask = 6'b000010;
        step();
        in_valid = 1'b0;
        #1;
        e = mk(1, 6'b000010, 3'd1, 1, 3'd1, 1);
        total++;
        if (obs !== e) $display("FAIL rmid_new got %b want %b", obs, e);
        else passed++;
        step();
    endtask

    task automatic test_stall();
        logic [14:0] e;
        in_valid = 1'b1; in_mask = 6'b010100; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 1);
            in_mask  = 6'b111111;
            #1;
            e = mk(1, 6'b010000, 3'd4, 0, 3'd2, 0);
            total++;
            if (obs !== e) $display("FAIL stall_c%0d got %b want %b", c, obs, e);
            else passed++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        e = mk(1, 6'b010000, 3'd4, 0, 3'd2, 0);
        total++;
        if (obs !== e) $display("FAIL stall_go4 got %b want %b", obs, e);
        else passed++;
        step();
        e = mk(1, 6'b000100, 3'd2, 1, 3'd1, 1);
        total++;
        if (obs !== e) $display("FAIL stall_go2 got %b want %b", obs, e);
        else passed++;
        step();
        e = mk(0, 6'b0, 3'd0, 0, 3'd0, 1);
        total++;
        if (obs !== e) $display("FAIL stall_idle got %b want %b", obs, e);
        else passed++;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall_toggle();
        test_back_to_back();
        test_zero_mask();
        test_reset_mid();
        test_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
